reset_sequencer: RTL and testbench

//  Producer side of the active-low asynchronous reset used by every flop in the design.

---
 rtl/rst_seq_pkg.sv | 21 ++
 rtl/reset_sync.sv | 23 ++
 rtl/reset_sequencer.sv | 118 +++++++++++
 tb/tb_reset_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and default
// timing parameters.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } seqState_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 8;
    localparam int DEF_NUM_STAGES  = 3;
    localparam int DEF_STAGE_GAP   = 4;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset de-assertion synchronizer: a shift register of ones.
// Asynchronously cleared, its output rises DEPTH clock edges after reset release.
module reset_sync #(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic sync_o
);

    logic [DEPTH-1:0] chain_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '0;
        end else begin
            chain_q <= (chain_q << 1) | DEPTH'(1);
        end
    end

    assign sync_o = chain_q[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced reset generator: async assertion, synchronised release, then the
// reset outputs are released one by one with a programmable gap.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int STAGE_GAP   = DEF_STAGE_GAP
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  SW_RST,
    output logic [NUM_STAGES-1:0] RST_OUT_n,
    output logic                  DONE
);

    localparam int CNT_W = $clog2(maxInt(HOLD_CYCLES, STAGE_GAP) + 1);
    localparam int IDX_W = $clog2(NUM_STAGES + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    seqState_e              state_q,    state_d;
    logic [CNT_W-1:0]       cnt_q,      cnt_d;
    logic [IDX_W-1:0]       stageIdx_q, stageIdx_d;
    logic [NUM_STAGES-1:0]  rstOut_q,   rstOut_d;
    logic                   done_q,     done_d;
    logic                   syncDone;

    // The state register acts as the last synchronizer flop, so the chain is
    // one shorter and HOLD is entered on edge SYNC_STAGES.
    reset_sync #(
        .DEPTH (SYNC_STAGES - 1)
    ) u_reset_sync (
        .clk_i  (CLK),
        .rst_ni (RST_n),
        .sync_o (syncDone)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= SYNC;
            cnt_q      <= '0;
            stageIdx_q <= '0;
            rstOut_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stageIdx_q <= stageIdx_d;
            rstOut_q   <= rstOut_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stageIdx_d = stageIdx_q;
        rstOut_d   = rstOut_q;
        done_d     = done_q;

        unique case (state_q)
            SYNC: begin
                if (syncDone) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d    = '0;
                    rstOut_d = rstOut_q | NUM_STAGES'(1);
                    if (NUM_STAGES == 1) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = RELEASE;
                        stageIdx_d = IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d      = '0;
                    rstOut_d   = rstOut_q | (NUM_STAGES'(1) << stageIdx_q);
                    stageIdx_d = stageIdx_q + IDX_W'(1);
                    if (stageIdx_q == IDX_LAST) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                // Software reset skips the synchronizer and restarts at HOLD.
                if (SW_RST) begin
                    state_d  = HOLD;
                    cnt_d    = '0;
                    rstOut_d = '0;
                    done_d   = 1'b0;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    assign RST_OUT_n = rstOut_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a minimal
// single-stage instance sharing the same clock and board reset.
module tb_reset_sequencer;

    logic       CLK;
    logic       RST_n;
    logic       SW_RST;
    logic [2:0] rstOut;
    logic       done;
    logic       smallSw;
    logic [0:0] smallRst;
    logic       smallDone;

    int checks;
    int errors;

    reset_sequencer #(
        .SYNC_STAGES (2),
        .HOLD_CYCLES (8),
        .NUM_STAGES  (3),
        .STAGE_GAP   (4)
    ) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .SW_RST    (SW_RST),
        .RST_OUT_n (rstOut),
        .DONE      (done)
    );

    reset_sequencer #(
        .SYNC_STAGES (2),
        .HOLD_CYCLES (1),
        .NUM_STAGES  (1),
        .STAGE_GAP   (1)
    ) dutSmall (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .SW_RST    (smallSw),
        .RST_OUT_n (smallRst),
        .DONE      (smallDone)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Expected default-instance outputs when stage 0 releases at edge relEdge.
    function automatic logic [2:0] expRst(input int e, input int relEdge);
        if (e < relEdge)          return 3'b000;
        else if (e < relEdge + 4) return 3'b001;
        else if (e < relEdge + 8) return 3'b011;
        else                      return 3'b111;
    endfunction

    task automatic checkOutput(input string tag, input logic [2:0] expR, input logic expD);
        checks++;
        assert ({rstOut, done} === {expR, expD}) else begin
            errors++;
            $error("FAIL %s: observed rst=%b done=%b expected rst=%b done=%b",
                   tag, rstOut, done, expR, expD);
        end
    endtask

    task automatic checkSmall(input string tag, input logic expR, input logic expD);
        checks++;
        assert ({smallRst, smallDone} === {expR, expD}) else begin
            errors++;
            $error("FAIL %s: observed rst=%b done=%b expected rst=%b done=%b",
                   tag, smallRst, smallDone, expR, expD);
        end
    endtask

    task automatic checkMonotonic(input string tag, input logic [2:0] prevRst);
        checks++;
        assert ((prevRst & ~rstOut) === 3'b000) else begin
            errors++;
            $error("FAIL %s: observed prev=%b now=%b expected no re-asserted bit",
                   tag, prevRst, rstOut);
        end
    endtask

    // Board reset pulse of 3ns, well inside one clock period.
    task automatic applyStimulus(input string tag);
        @(posedge CLK);
        #3 RST_n = 1'b0;
        #1;
        checkOutput({tag, "_async"}, 3'b000, 1'b0);
        checkSmall({tag, "_async_small"}, 1'b0, 1'b0);
        #2 RST_n = 1'b1;
    endtask

    task automatic checkSequence(input string tag, input int firstEdge, input int lastEdge,
                                 input int relEdge, input int swA, input int swB,
                                 input bit withSmall);
        logic [2:0] prevRst;
        prevRst = rstOut;
        for (int e = firstEdge; e <= lastEdge; e++) begin
            SW_RST = (e == swA) || (e == swB);
            @(posedge CLK);
            #1;
            checkOutput($sformatf("%s_e%0d", tag, e), expRst(e, relEdge), (e >= relEdge + 8));
            if (e > firstEdge)
                checkMonotonic($sformatf("%s_mono_e%0d", tag, e), prevRst);
            if (withSmall && e <= 4)
                checkSmall($sformatf("%s_small_e%0d", tag, e), (e >= 3), (e >= 3));
            prevRst = rstOut;
        end
        SW_RST = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        RST_n   = 1'b0;
        SW_RST  = 1'b0;
        smallSw = 1'b0;

        #2;
        checkOutput("reset_state", 3'b000, 1'b0);
        checkSmall("reset_state_small", 1'b0, 1'b0);

        // Power-on release between edges; edge 1 is the next rising edge.
        @(posedge CLK);
        @(posedge CLK);
        #3 RST_n = 1'b1;
        checkSequence("poweron", 1, 22, 10, -1, -1, 1'b1);

        // Software reset sampled at relative edge 0 while in RUN.
        checkSequence("swrst", 0, 20, 8, 0, -1, 1'b0);

        // Short asynchronous pulse while in RUN, then full sequence again.
        applyStimulus("pulse");
        checkSequence("after_pulse", 1, 22, 10, -1, -1, 1'b0);

        // Board reset lands at edge 12 mid-sequence and lifts before edge 20.
        applyStimulus("mid_start");
        checkSequence("mid_a", 1, 12, 10, -1, -1, 1'b0);
        RST_n = 1'b0;
        #1;
        checkOutput("mid_assert", 3'b000, 1'b0);
        checkSequence("mid_low", 13, 19, 29, -1, -1, 1'b0);
        RST_n = 1'b1;
        checkSequence("mid_b", 20, 40, 29, -1, -1, 1'b0);

        // Software reset pulses during HOLD and RELEASE are ignored.
        applyStimulus("ignsw_start");
        checkSequence("ignsw", 1, 22, 10, 5, 12, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
